// File: rtl/addsub_pkg.sv
// Shared types and constants for the multi-byte add/subtract sequencer.
package addsub_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub.sv
// 8-bit adder-subtractor: {cout,sum} = a + (b ^ {8{add_sub}}) + cin.
module addsub
   import addsub_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              cin,
   input  logic              add_sub,
   output logic [BYTE_W-1:0] sum,
   output logic              cout
);

   logic [BYTE_W-1:0] b_eff;

   // Invert b for subtraction; the caller supplies the +1 through cin.
   assign b_eff = b ^ {BYTE_W{add_sub}};

   // Single ripple add producing carry-out and byte sum.
   assign {cout, sum} = (BYTE_W+1)'(a) + (BYTE_W+1)'(b_eff) + (BYTE_W+1)'(cin);

endmodule

// File: rtl/addsub_seq.sv
// Wide add/subtract built by stepping one shared 8-bit addsub over the
// operands, least-significant byte first, with a registered carry chain.
module addsub_seq
   import addsub_pkg::*;
#(
   parameter  int unsigned NBYTES = 4,
   localparam int unsigned IDXW   = $clog2(NBYTES),
   localparam int unsigned W      = 8 * NBYTES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_op,
   input  logic [W-1:0] req_a,
   input  logic [W-1:0] req_b,
   input  logic         req_cin,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_result,
   output logic         rsp_cout,
   output logic         rsp_zero,
   output logic         rsp_ovf,
   output logic         busy
);

   state_t state, state_next;

   logic [NBYTES-1:0][BYTE_W-1:0] a_reg, b_reg, res_reg, res_upd;
   logic                          op_reg;
   logic                          carry_reg;
   logic [IDXW-1:0]               idx;

   logic [BYTE_W-1:0] dp_a, dp_b, dp_sum;
   logic              dp_cout;
   logic              last_c;
   logic              ovf_c;

   // Byte mux into the datapath and result image including the current byte.
   always_comb begin
      dp_a           = a_reg[idx];
      dp_b           = b_reg[idx];
      last_c         = (idx == IDXW'(NBYTES - 1));
      res_upd        = res_reg;
      res_upd[idx]   = dp_sum;
      // Effective b sign is inverted for subtract; overflow when the
      // operand signs agree and the result sign differs from a.
      ovf_c          = (a_reg[NBYTES-1][BYTE_W-1] == (b_reg[NBYTES-1][BYTE_W-1] ^ op_reg)) &&
                       (dp_sum[BYTE_W-1] != a_reg[NBYTES-1][BYTE_W-1]);
   end

   addsub u_addsub (
      .a       (dp_a),
      .b       (dp_b),
      .cin     (carry_reg),
      .add_sub (op_reg),
      .sum     (dp_sum),
      .cout    (dp_cout)
   );

   // Next-state logic for the IDLE -> RUN -> DONE sequence.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (req_valid) state_next = RUN;
         RUN:     if (last_c)    state_next = DONE;
         DONE:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register and registered handshake/status flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         req_ready <= (state_next == IDLE);
         rsp_valid <= (state_next == DONE);
         busy      <= (state_next != IDLE);
      end
   end

   // Operand capture, per-byte result write, carry chain and final flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= '0;
         op_reg    <= OP_ADD;
         carry_reg <= 1'b0;
         idx       <= '0;
         rsp_cout  <= 1'b0;
         rsp_zero  <= 1'b0;
         rsp_ovf   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  a_reg     <= req_a;
                  b_reg     <= req_b;
                  op_reg    <= req_op;
                  idx       <= '0;
                  carry_reg <= (req_op == OP_SUB) ? ~req_cin : req_cin;
               end
            end
            RUN: begin
               res_reg[idx] <= dp_sum;
               carry_reg    <= dp_cout;
               if (last_c) begin
                  rsp_cout <= dp_cout;
                  rsp_zero <= (res_upd == '0);
                  rsp_ovf  <= ovf_c;
               end else begin
                  idx <= idx + IDXW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_result = res_reg;

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq (NBYTES = 4).
module tb_addsub_seq;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid, req_ready, req_op, req_cin;
   logic [W-1:0] req_a, req_b;
   logic         rsp_valid, rsp_ready, rsp_cout, rsp_zero, rsp_ovf, busy;
   logic [W-1:0] rsp_result;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic         op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] r;
      logic         c;
      logic         z;
      logic         v;
   } vec_t;

   vec_t vecs[9];

   addsub_seq #(.NBYTES(NB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_cin    (req_cin),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_cout   (rsp_cout),
      .rsp_zero   (rsp_zero),
      .rsp_ovf    (rsp_ovf),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wide reference: returns {ovf, zero, cout, result}.
   function automatic logic [W+2:0] model(input logic op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cin);
      logic [W:0]   full;
      logic [W-1:0] bx;
      logic         ci, ov;
      bx   = op ? ~b : b;
      ci   = op ? ~cin : cin;
      full = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, ci};
      if (op) ov = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
      else    ov = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
      return {ov, (full[W-1:0] == '0), full[W], full[W-1:0]};
   endfunction

   // One complete operation: accept, latency/busy check, capture, handshake.
   task automatic do_op(input string tag, input logic op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin, input bit rnd,
                        output logic [W-1:0] r, output logic c, output logic z,
                        output logic v);
      int lat;
      bit busy_ok;
      bit r_rdy;
      check({tag, " req_ready"}, 64'(req_ready), 64'(1));
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_cin   = cin;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      req_a     = ~a;
      req_b     = W'($urandom);
      req_op    = ~op;
      req_cin   = ~cin;
      lat       = 0;
      busy_ok   = 1'b1;
      while (!rsp_valid && lat < 20) begin
         if (!busy) busy_ok = 1'b0;
         if (rnd) rsp_ready = 1'($urandom_range(0, 1));
         tick();
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(NB));
      check({tag, " busy"}, 64'(busy_ok && busy), 64'(1));
      r = rsp_result;
      c = rsp_cout;
      z = rsp_zero;
      v = rsp_ovf;
      for (int k = 0; k < 20; k++) begin
         r_rdy     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         rsp_ready = r_rdy;
         tick();
         if (r_rdy) break;
      end
      rsp_ready = 1'b0;
      check({tag, " rsp_valid_drop"}, 64'(rsp_valid), 64'(0));
   endtask

   initial begin
      logic [W-1:0]   r;
      logic           c, z, v;
      logic [W+2:0]   exp;
      logic           op_r, cin_r;
      logic [W-1:0]   a_r, b_r;
      int             lat;
      bit             seen;

      vecs[0] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 32'h0000_0005, 32'h0000_0002, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 32'h0000_1234, 32'h0000_1234, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
      vecs[8] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_op    = 1'b0;
      req_a     = '0;
      req_b     = '0;
      req_cin   = 1'b0;
      rsp_ready = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;

      check("reset req_ready", 64'(req_ready), 64'(1));
      check("reset rsp_valid", 64'(rsp_valid), 64'(0));
      check("reset rsp_result", 64'(rsp_result), 64'(0));
      check("reset rsp_cout", 64'(rsp_cout), 64'(0));
      check("reset rsp_zero", 64'(rsp_zero), 64'(0));
      check("reset rsp_ovf", 64'(rsp_ovf), 64'(0));
      check("reset busy", 64'(busy), 64'(0));

      // Directed vector table.
      for (int i = 0; i < 9; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
               r, c, z, v);
         check($sformatf("vec%0d result", i), 64'(r), 64'(vecs[i].r));
         check($sformatf("vec%0d cout", i), 64'(c), 64'(vecs[i].c));
         check($sformatf("vec%0d zero", i), 64'(z), 64'(vecs[i].z));
         check($sformatf("vec%0d ovf", i), 64'(v), 64'(vecs[i].v));
      end

      // Backpressure in DONE with a second request pending.
      req_op    = 1'b0;
      req_a     = 32'd1;
      req_b     = 32'd2;
      req_cin   = 1'b0;
      req_valid = 1'b1;
      tick();
      req_a = 32'd10;
      req_b = 32'd20;
      lat   = 0;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("bp latency", 64'(lat), 64'(NB));
      for (int i = 0; i < 5; i++) begin
         check("bp result held", 64'(rsp_result), 64'(3));
         check("bp req_ready low", 64'(req_ready), 64'(0));
         check("bp rsp_valid held", 64'(rsp_valid), 64'(1));
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("bp idle req_ready", 64'(req_ready), 64'(1));
      check("bp idle rsp_valid", 64'(rsp_valid), 64'(0));
      check("bp idle busy", 64'(busy), 64'(0));
      tick();
      req_valid = 1'b0;
      check("bp second accepted busy", 64'(busy), 64'(1));
      check("bp second req_ready", 64'(req_ready), 64'(0));
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("bp second latency", 64'(lat), 64'(NB));
      check("bp second result", 64'(rsp_result), 64'(30));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Reset asserted at the edge that would process byte 2.
      req_op    = 1'b0;
      req_a     = 32'h1122_3344;
      req_b     = 32'h0000_0001;
      req_cin   = 1'b0;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst req_ready", 64'(req_ready), 64'(1));
      check("midrst rsp_valid", 64'(rsp_valid), 64'(0));
      check("midrst rsp_result", 64'(rsp_result), 64'(0));
      check("midrst rsp_cout", 64'(rsp_cout), 64'(0));
      check("midrst rsp_zero", 64'(rsp_zero), 64'(0));
      check("midrst rsp_ovf", 64'(rsp_ovf), 64'(0));
      check("midrst busy", 64'(busy), 64'(0));
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (rsp_valid) seen = 1'b1;
         tick();
      end
      check("midrst no response", 64'(seen), 64'(0));
      do_op("postrst", 1'b0, 32'd1, 32'd1, 1'b0, 1'b0, r, c, z, v);
      check("postrst result", 64'(r), 64'(2));

      // Random regression against the wide reference.
      for (int i = 0; i < 1000; i++) begin
         op_r  = 1'($urandom_range(0, 1));
         cin_r = 1'($urandom_range(0, 1));
         a_r   = W'($urandom);
         b_r   = W'($urandom);
         if (i % 8 == 0) b_r = a_r;
         exp = model(op_r, a_r, b_r, cin_r);
         do_op("rnd", op_r, a_r, b_r, cin_r, 1'b1, r, c, z, v);
         check($sformatf("rnd%0d result", i), 64'(r), 64'(exp[W-1:0]));
         check($sformatf("rnd%0d cout", i), 64'(c), 64'(exp[W]));
         check($sformatf("rnd%0d zero", i), 64'(z), 64'(exp[W+1]));
         check($sformatf("rnd%0d ovf", i), 64'(v), 64'(exp[W+2]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
Multi-byte add/subtract sequencer built around the existing 8-bit `addsub` datapath.
- Accepts one wide operation (NBYTES bytes per operand) over a valid/ready request channel.
- Passes the operands through a single `addsub` instance one byte per cycle, least-significant byte first, chaining the carry through a register.
- Returns the wide result, final carry, zero flag and signed overflow on a valid/ready response channel.
- Lets the team run 16/32/64-bit arithmetic on the 8-bit adder-subtractor without replicating it.

Parameters:
NBYTES, 4, operand width in bytes (W = 8*NBYTES); legal range 2..16.
IDXW, $clog2(NBYTES), width of the byte-index counter (derived; not overridden).

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready at a clk edge
req_op  in  1  0 = add, 1 = subtract (a - b)
req_a  in  W  operand a
req_b  in  W  operand b
req_cin  in  1  add: carry-in; subtract: borrow-in (active high)
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a clk edge
rsp_result  out  W  result
rsp_cout  out  1  raw final carry from byte NBYTES-1 (for subtract: 1 = no borrow)
rsp_zero  out  1  rsp_result == 0
rsp_ovf  out  1  two's-complement signed overflow
busy  out  1  high in RUN or DONE

Behaviour:
Datapath contract:
- `addsub` computes {cout,sum} = a + (b XOR {8{add_sub}}) + cin, combinationally.
- The controller drives all four inputs of `addsub`.

FSM states: IDLE, RUN, DONE.

IDLE:
- req_ready = 1.
- On handshake: latch req_a, req_b and req_op; set idx = 0.
- Carry register: req_cin for add; ~req_cin for subtract.
- Go to RUN.

RUN:
- req_ready = 0.
- `addsub` inputs: a = a_reg[idx], b = b_reg[idx], add_sub = op_reg, cin = carry_reg.
- Each edge: result_reg[idx] <= sum; carry_reg <= cout; idx <= idx + 1.
- At the edge processing idx == NBYTES-1, go to DONE instead of incrementing.

DONE:
- rsp_valid = 1. rsp_result, rsp_cout, rsp_zero and rsp_ovf are registered and held stable until the response handshake.
- On the handshake, go to IDLE.
- rsp_ready is ignored outside DONE.

Latency and throughput:
- rsp_valid rises exactly NBYTES cycles after the accepting edge.
- The earliest next accept is 1 cycle after the response handshake (back in IDLE).
- There is no overlap of operations.

Flags:
- ovf, add: a[W-1] == b[W-1] && r[W-1] != a[W-1].
- ovf, subtract: a[W-1] != b[W-1] && r[W-1] != a[W-1].
- rsp_zero is computed from the full result.

Boundary and simultaneous-event rules:
- req_valid while not IDLE: ignored, not latched.
- Operands changing after accept: no effect on the operation in progress.
- req_valid held with rsp_ready low: the block stays in DONE indefinitely, outputs frozen, req_ready 0.

Reset (rst_n low at a clk edge, any state including mid-RUN):
- State goes to IDLE; the in-flight operation is discarded and no response is produced.
- Reset values: req_ready 1, rsp_valid 0, rsp_result 0, rsp_cout 0, rsp_zero 0, rsp_ovf 0, busy 0.
- idx and carry_reg are cleared.

Decomposition:
Shared package addsub_pkg:
- State enum (IDLE/RUN/DONE).
- Opcode constants OP_ADD = 1'b0 and OP_SUB = 1'b1.

Sub-module:
- One instance of the existing `addsub` (ports a, b, cin, add_sub, sum, cout) as the only arithmetic.
- No other sub-module; the FSM, index counter and byte mux/demux live in addsub_seq.

Test Plan (NBYTES=4):
1. Add 0x000000FF + 0x00000001, cin 0 -> result 0x00000100, cout 0, zero 0, ovf 0; rsp_valid exactly 4 cycles after accept; busy high throughout.
2. Add 0xFFFFFFFF + 0x00000001, cin 0 -> result 0x00000000, cout 1, zero 1, ovf 0. Add 0x7FFFFFFF + 0x00000001 -> 0x80000000, ovf 1.
3. Sub 0x00000000 - 0x00000001, borrow 0 -> result 0xFFFFFFFF, cout 0, ovf 0. Sub 0x80000000 - 0x00000001 -> 0x7FFFFFFF, cout 1, ovf 1. Sub 5 - 2 with borrow-in 1 -> 0x00000002.
4. Backpressure: hold rsp_ready low 5 cycles in DONE while driving a new req_valid -> outputs stable, req_ready 0, second request not latched; after the handshake, req_ready 1 next cycle and the second request is accepted.
5. Reset mid-RUN (rst_n low at the edge processing idx 2) -> next cycle IDLE, req_ready 1, rsp_valid 0, all outputs at reset values; a following add 1 + 1 returns 0x00000002.
6. Random regression: 1000 random ops/operands/cin against a W-bit reference model for result, cout, zero and ovf; rsp_ready randomly toggled.
